// File: rtl/bgm_sequencer.sv
// ---------------------------------------------------------------------------
// bgm_sequencer
//   Background-music note sequencer. Selects one of NUM_TRACKS tracks from the
//   game-state code on track_sel. Before each track it inserts a silent gap,
//   then steps a note ROM address at a per-track beat rate. One-shot tracks end
//   with a single-cycle done pulse. Looping tracks wrap back to note 0.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous reset, active high
//   track_sel  in   requested track code (game state)
//   restart    in   single-cycle pulse, restarts the current track
//   mute       in   forces silent tone output; sequencing is unaffected
//   trk_len    in   note count of track_sel (external track table)
//   trk_div    in   clk cycles per note of track_sel (0 is treated as 1)
//   trk_loop   in   1 = looping track, 0 = one-shot track
//   note_addr  out  registered note ROM address
//   note_l/r   in   ROM tone data, valid one cycle after note_addr
//   freqL/R    out  registered tone codes (SILENCE when not sounding)
//   playing    out  high while a track is being stepped
//   done       out  single-cycle pulse when a one-shot track ends
//   cur_track  out  latched track code
// ---------------------------------------------------------------------------
module bgm_sequencer #(
  parameter int          NUM_TRACKS = 10,
  parameter int          SEL_W      = 4,
  parameter int          ADDR_W     = 12,
  parameter int          DIV_W      = 24,
  parameter int          GAP_CYCLES = 2000000,
  parameter logic [25:0] SILENCE    = 26'd50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEL_W-1:0]  track_sel,
  input  logic              restart,
  input  logic              mute,
  input  logic [ADDR_W-1:0] trk_len,
  input  logic [DIV_W-1:0]  trk_div,
  input  logic              trk_loop,
  output logic [ADDR_W-1:0] note_addr,
  input  logic [25:0]       note_l,
  input  logic [25:0]       note_r,
  output logic [25:0]       freqL,
  output logic [25:0]       freqR,
  output logic              playing,
  output logic              done,
  output logic [SEL_W-1:0]  cur_track
);

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_PLAY, S_DONE} state_t;

  // The gap counter runs 0..GAP_CYCLES-1, so GAP occupies exactly GAP_CYCLES cycles.
  localparam int              GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t            r_state;
  logic [SEL_W-1:0]  r_cur_track;
  logic [ADDR_W-1:0] r_note_addr;
  logic [DIV_W-1:0]  r_beat;
  logic [GAP_W-1:0]  r_gap;
  logic [ADDR_W-1:0] r_len;
  logic [DIV_W-1:0]  r_div;
  logic              r_loop;
  logic [25:0]       r_freq_l;
  logic [25:0]       r_freq_r;
  logic              r_done;

  state_t            w_state_nxt;
  logic [SEL_W-1:0]  w_cur_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DIV_W-1:0]  w_beat_nxt;
  logic [GAP_W-1:0]  w_gap_nxt;
  logic              w_load;
  logic              w_done_nxt;
  logic              w_start_req;
  logic              w_sel_valid;
  logic              w_audible;
  logic [DIV_W-1:0]  w_div_last;
  logic [ADDR_W-1:0] w_addr_last;

  // A restart pulse and a track change in the same cycle collapse into one start.
  assign w_start_req = restart || (track_sel != r_cur_track);
  assign w_sel_valid = int'(track_sel) < NUM_TRACKS;

  // r_div is never 0 and r_len is never 0 while in PLAY, so these cannot underflow there.
  assign w_div_last  = r_div - DIV_W'(1);
  assign w_addr_last = r_len - ADDR_W'(1);

  // A start request silences the output on the very next cycle, even if
  // the FSM was still in PLAY when the request was sampled.
  assign w_audible   = (r_state == S_PLAY) && !mute && !w_start_req;

  // Next-state and counter logic.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur_track;
    w_addr_nxt  = r_note_addr;
    w_beat_nxt  = r_beat;
    w_gap_nxt   = r_gap;
    w_load      = 1'b0;
    w_done_nxt  = 1'b0;

    if (w_start_req) begin
      // Start requests win from every state, including GAP itself.
      w_cur_nxt   = track_sel;
      w_gap_nxt   = '0;
      w_state_nxt = w_sel_valid ? S_GAP : S_IDLE;
    end else begin
      case (r_state)
        S_GAP: begin
          if (r_gap == GAP_LAST) begin
            w_load     = 1'b1;
            w_addr_nxt = '0;
            w_beat_nxt = '0;
            if (trk_len == '0) begin
              w_state_nxt = S_DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_PLAY;
            end
          end else begin
            w_gap_nxt = r_gap + GAP_W'(1);
          end
        end
        S_PLAY: begin
          if (r_beat == w_div_last) begin
            w_beat_nxt = '0;
            if (r_note_addr == w_addr_last) begin
              if (r_loop) begin
                w_addr_nxt = '0;
              end else begin
                // One-shot end: note_addr stays on the last note.
                w_state_nxt = S_DONE;
                w_done_nxt  = 1'b1;
              end
            end else begin
              w_addr_nxt = r_note_addr + ADDR_W'(1);
            end
          end else begin
            w_beat_nxt = r_beat + DIV_W'(1);
          end
        end
        default: ; // IDLE and DONE wait for a start request
      endcase
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      r_state     <= S_IDLE;
      r_cur_track <= '1;
      r_note_addr <= '0;
      r_beat      <= '0;
      r_gap       <= '0;
      r_len       <= '0;
      r_div       <= DIV_W'(1);
      r_loop      <= 1'b0;
      r_freq_l    <= SILENCE;
      r_freq_r    <= SILENCE;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_track <= w_cur_nxt;
      r_note_addr <= w_addr_nxt;
      r_beat      <= w_beat_nxt;
      r_gap       <= w_gap_nxt;
      r_done      <= w_done_nxt;
      if (w_load) begin
        // Track parameters are frozen here; later table changes wait for the next start.
        r_len  <= trk_len;
        r_div  <= (trk_div == '0) ? DIV_W'(1) : trk_div;
        r_loop <= trk_loop;
      end
      r_freq_l <= w_audible ? note_l : SILENCE;
      r_freq_r <= w_audible ? note_r : SILENCE;
    end
  end

  assign note_addr = r_note_addr;
  assign freqL     = r_freq_l;
  assign freqR     = r_freq_r;
  assign playing   = (r_state == S_PLAY);
  assign done      = r_done;
  assign cur_track = r_cur_track;

endmodule
